serial_pattern_tx: RTL and testbench
====================================

Name: serial_pattern_tx

Overview:
- Serial stimulus transmitter that drives the two-bit serial input pair (`sdata`, `saux`) consumed by the team's sequence-detecting FSMs.
- Accepts a parallel pattern/aux word plus a bit length through a start/ready handshake.
- Shifts the word out MSB first, one bit per clock, then pulses `done` and holds a programmable idle gap before the next frame.
- Sits between test/control logic and the sequence-detector FSMs.

Parameters:
- WIDTH, 8, width of pattern and aux words (max frame length, >=2)
- CNT_W, 4, width of len input; must satisfy 2^CNT_W > WIDTH
- GAP, 2, idle cycles inserted after each frame (0 allowed)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a frame; accepted only when ready=1
- pattern  input  WIDTH  bits for sdata, MSB sent first
- aux  input  WIDTH  bits for saux, aligned bit-for-bit with pattern
- len  input  CNT_W  number of bits to send
- abort  input  1  terminate current frame
- ready  output  1  1 when IDLE and able to accept start
- sdata  output  1  serial data bit (registered)
- saux  output  1  serial companion bit (registered)
- sval  output  1  1 while sdata/saux carry a valid frame bit
- busy  output  1  1 in SHIFT or GAP
- done  output  1  one-cycle pulse after last bit of a completed frame

Behaviour:
- One clock (`clk`); reset is synchronous and active-high (`reset`). Reset is sampled only on the clk rising edge.
- Reset values: state=IDLE, sdata=0, saux=0, sval=0, done=0, busy=0, ready=1. Reset overrides all other inputs, including mid-frame; no done is generated on reset.
- States: IDLE, SHIFT, GAP. ready=(state==IDLE), busy=~ready, both decoded from state.
- IDLE:
  - start=1 with len!=0 and abort=0 at edge T: latch pattern/aux into shift registers, latch effective length L=min(len,WIDTH), go to SHIFT.
  - start with len==0 is ignored: no state change, no done.
- SHIFT, cycles T+1 .. T+L:
  - cycle T+k drives sval=1, sdata=pattern[WIDTH-k], saux=aux[WIDTH-k].
  - Bit counter decrements; after the last bit, next state is GAP (GAP>0) or IDLE (GAP=0).
- Completion, cycle T+L+1: done=1 for exactly one cycle; sval=0, sdata=0, saux=0.
  - GAP>0: remain in GAP for cycles T+L+1 .. T+L+GAP; ready=1 at T+L+GAP+1.
  - GAP=0: ready=1 at T+L+1, in the same cycle as done. A start in that cycle is accepted, giving back-to-back frames with a single idle bit slot.
- start while busy: ignored, not queued. pattern/aux/len are not sampled outside acceptance.
- abort:
  - In SHIFT or GAP: next edge forces IDLE, sval/sdata/saux=0, no done pulse, gap skipped.
  - In IDLE: abort=1 blocks a simultaneous start.
  - On the last-bit cycle, abort wins over completion: no done.
- Clamping: len>WIDTH sends exactly WIDTH bits.
- sdata/saux are forced to 0 whenever sval=0.

Test Plan:
- Reset: hold reset 2 cycles during an active frame -> next cycle ready=1, busy=0, sval=0, sdata=0, done=0; no done ever seen.
- WIDTH=8, GAP=2; start with pattern=8'b1011_0010, aux=8'hFF, len=8 at T -> sdata 1,0,1,1,0,0,1,0 with sval=1, saux=1 at T+1..T+8; done=1 at T+9 only; ready=1 at T+11.
- Short frame: pattern=8'hE0, aux=8'h40, len=3 -> sdata 1,1,1 / saux 0,1,0 at T+1..T+3; done at T+4. len=0 start -> no activity, ready stays 1. len=12 -> exactly 8 bits sent.
- start pulsed at T+4 during an 8-bit frame -> ignored; frame unchanged; exactly one done.
- abort at T+3 of an 8-bit frame -> sval=0 from T+4, ready=1 at T+4, no done. abort+start same cycle in IDLE -> no frame.
- GAP=0 build: start held high continuously with len=2 -> frames separated by one non-valid cycle in which done=1 and ready=1; each frame yields one done.

Source files
------------

// File: rtl/serial_pattern_tx_if.sv
// Bus bundle for serial_pattern_tx: frame request handshake plus serial outputs.
// Signal prefixes follow the transmitter's point of view: i_ = into it, o_ = out of it.
interface serial_pattern_tx_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             i_start;
    logic [WIDTH-1:0] i_pattern;
    logic [WIDTH-1:0] i_aux;
    logic [CNT_W-1:0] i_len;
    logic             i_abort;
    logic             o_ready;
    logic             o_sdata;
    logic             o_saux;
    logic             o_sval;
    logic             o_busy;
    logic             o_done;

    modport slave (
        input  i_start, i_pattern, i_aux, i_len, i_abort,
        output o_ready, o_sdata, o_saux, o_sval, o_busy, o_done
    );

    modport master (
        output i_start, i_pattern, i_aux, i_len, i_abort,
        input  o_ready, o_sdata, o_saux, o_sval, o_busy, o_done
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial stimulus transmitter: shifts a pattern/aux word pair out MSB first,
// one bit per clock, pulses done after a completed frame, then idles GAP cycles.
module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int GAP   = 2
) (
    input  logic               clk,
    input  logic               reset,
    serial_pattern_tx_if.slave bus
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [WIDTH-1:0]   r_patSr;
    logic [WIDTH-1:0]   r_auxSr;
    logic [CNT_W-1:0]   r_bitCnt;
    logic [GAP_W-1:0]   r_gapCnt;
    logic               r_sdata;
    logic               r_saux;
    logic               r_sval;
    logic               r_done;

    logic [WIDTH-1:0]   w_patNext;
    logic [WIDTH-1:0]   w_auxNext;
    logic [CNT_W-1:0]   w_bitCntNext;
    logic [GAP_W-1:0]   w_gapCntNext;
    logic               w_sdataNext;
    logic               w_sauxNext;
    logic               w_svalNext;
    logic               w_doneNext;
    logic [CNT_W-1:0]   w_lenEff;

    // Requested lengths beyond the word width are clamped to a full word.
    assign w_lenEff = (bus.i_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.i_len;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and next-output decode; serial outputs default to 0 so they are low whenever no bit is valid.
    always_comb begin
        w_stateNext  = r_state;
        w_patNext    = r_patSr;
        w_auxNext    = r_auxSr;
        w_bitCntNext = r_bitCnt;
        w_gapCntNext = r_gapCnt;
        w_sdataNext  = 1'b0;
        w_sauxNext   = 1'b0;
        w_svalNext   = 1'b0;
        w_doneNext   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.i_start && !bus.i_abort && (bus.i_len != '0)) begin
                    w_stateNext  = ST_SHIFT;
                    w_svalNext   = 1'b1;
                    w_sdataNext  = bus.i_pattern[WIDTH-1];
                    w_sauxNext   = bus.i_aux[WIDTH-1];
                    w_patNext    = bus.i_pattern << 1;
                    w_auxNext    = bus.i_aux << 1;
                    w_bitCntNext = w_lenEff;
                end
            end
            ST_SHIFT: begin
                if (bus.i_abort) begin
                    w_stateNext = ST_IDLE;
                end else if (r_bitCnt > CNT_W'(1)) begin
                    w_svalNext   = 1'b1;
                    w_sdataNext  = r_patSr[WIDTH-1];
                    w_sauxNext   = r_auxSr[WIDTH-1];
                    w_patNext    = r_patSr << 1;
                    w_auxNext    = r_auxSr << 1;
                    w_bitCntNext = r_bitCnt - CNT_W'(1);
                end else begin
                    w_doneNext = 1'b1;
                    if (GAP > 0) begin
                        w_stateNext  = ST_GAP;
                        w_gapCntNext = GAP_W'(GAP);
                    end else begin
                        w_stateNext = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (bus.i_abort || (r_gapCnt <= GAP_W'(1))) begin
                    w_stateNext = ST_IDLE;
                end else begin
                    w_gapCntNext = r_gapCnt - GAP_W'(1);
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: shift registers, counters and the registered serial outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_patSr  <= '0;
            r_auxSr  <= '0;
            r_bitCnt <= '0;
            r_gapCnt <= '0;
            r_sdata  <= 1'b0;
            r_saux   <= 1'b0;
            r_sval   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_patSr  <= w_patNext;
            r_auxSr  <= w_auxNext;
            r_bitCnt <= w_bitCntNext;
            r_gapCnt <= w_gapCntNext;
            r_sdata  <= w_sdataNext;
            r_saux   <= w_sauxNext;
            r_sval   <= w_svalNext;
            r_done   <= w_doneNext;
        end
    end

    assign bus.o_ready = (r_state == ST_IDLE);
    assign bus.o_busy  = (r_state != ST_IDLE);
    assign bus.o_sdata = r_sdata;
    assign bus.o_saux  = r_saux;
    assign bus.o_sval  = r_sval;
    assign bus.o_done  = r_done;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx: stimulus pushes expected serial
// events into a queue, a negedge monitor pops and compares them.
module tb_serial_pattern_tx;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int GAP   = 2;

    typedef struct {
        int cyc;
        bit isDone;
        bit sd;
        bit sa;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   monEn = 1'b0;
    exp_t expQ[$];

    serial_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
    serial_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus0 ();

    serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W), .GAP(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    // Free-running clock and cycle index (cycle k spans posedge k .. posedge k+1).
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every valid bit or done pulse must match the next queued event.
    always @(negedge clk) begin
        exp_t e;
        if (monEn) begin
            while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
                e = expQ.pop_front();
                checkOutput("missing event", cyc, e.cyc);
            end
            if (bus.o_sval || bus.o_done) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected output", {bus.o_sval, bus.o_done}, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("event cycle", cyc, e.cyc);
                    checkOutput("event kind done", bus.o_done, e.isDone);
                    checkOutput("event kind sval", bus.o_sval, !e.isDone);
                    if (!e.isDone) begin
                        checkOutput("sdata", bus.o_sdata, e.sd);
                        checkOutput("saux", bus.o_saux, e.sa);
                    end
                end
            end else begin
                checkOutput("idle serial lines", {bus.o_sdata, bus.o_saux}, 0);
            end
        end
    end

    // Issue one frame request in the current cycle and follow it to the point ready returns.
    task automatic applyStimulus(input logic [WIDTH-1:0] pat, input logic [WIDTH-1:0] ax,
                                 input int ln, input int abortAt, input bit poke);
        int c;
        int L;
        int nBits;
        exp_t e;
        checkOutput("ready before start", bus.o_ready, 1);
        c = cyc;
        bus.i_start   = 1'b1;
        bus.i_abort   = 1'b0;
        bus.i_pattern = pat;
        bus.i_aux     = ax;
        bus.i_len     = CNT_W'(ln);
        L = (ln == 0) ? 0 : ((ln > WIDTH) ? WIDTH : ln);
        if (L == 0) begin
            tick();
            bus.i_start = 1'b0;
            checkOutput("len0 ready", bus.o_ready, 1);
            checkOutput("len0 busy", bus.o_busy, 0);
            return;
        end
        nBits = (abortAt > 0) ? abortAt : L;
        for (int k = 1; k <= nBits; k++) begin
            e.cyc = c + k; e.isDone = 1'b0; e.sd = pat[WIDTH-k]; e.sa = ax[WIDTH-k];
            expQ.push_back(e);
        end
        if (abortAt == 0) begin
            e.cyc = c + L + 1; e.isDone = 1'b1; e.sd = 1'b0; e.sa = 1'b0;
            expQ.push_back(e);
        end
        for (int k = 1; k <= WIDTH + GAP + 2; k++) begin
            tick();
            bus.i_start   = 1'b0;
            bus.i_abort   = 1'b0;
            bus.i_pattern = WIDTH'($urandom);
            bus.i_aux     = WIDTH'($urandom);
            bus.i_len     = CNT_W'($urandom);
            if (abortAt > 0) begin
                if (k == abortAt + 1) begin
                    checkOutput("ready after abort", bus.o_ready, 1);
                    checkOutput("busy after abort", bus.o_busy, 0);
                    break;
                end
            end else begin
                if (k == L + GAP) checkOutput("busy in gap", bus.o_busy, 1);
                if (k == L + GAP + 1) begin
                    checkOutput("ready after gap", bus.o_ready, 1);
                    break;
                end
            end
            if (poke && k == 4) bus.i_start = 1'b1;
            if (abortAt > 0 && k == abortAt) bus.i_abort = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c;
        int L;
        int ab;
        bit pk;
        int dones;
        exp_t e;
        reset = 1'b1;
        bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_pattern = '0; bus.i_aux = '0; bus.i_len = '0;
        bus0.i_start = 1'b0; bus0.i_abort = 1'b0; bus0.i_pattern = '0; bus0.i_aux = '0; bus0.i_len = '0;
        repeat (3) tick();
        reset = 1'b0;
        checkOutput("reset ready", bus.o_ready, 1);
        checkOutput("reset busy", bus.o_busy, 0);
        checkOutput("reset sval", bus.o_sval, 0);
        checkOutput("reset sdata", bus.o_sdata, 0);
        checkOutput("reset saux", bus.o_saux, 0);
        checkOutput("reset done", bus.o_done, 0);
        monEn = 1'b1;
        tick();

        $display("[TB] directed frames");
        applyStimulus(8'b1011_0010, 8'hFF, 8, 0, 0);
        applyStimulus(8'hE0, 8'h40, 3, 0, 0);
        applyStimulus(8'h5A, 8'h3C, 0, 0, 0);
        applyStimulus(8'hA7, 8'h19, 12, 0, 0);
        applyStimulus(8'hC3, 8'h96, 8, 0, 1);
        applyStimulus(8'h6D, 8'hB2, 8, 3, 0);
        applyStimulus(8'h9E, 8'h71, 5, 5, 0);

        // Abort together with start in IDLE must not launch a frame.
        bus.i_start = 1'b1; bus.i_abort = 1'b1; bus.i_len = 4'd8; bus.i_pattern = 8'hFF;
        tick();
        bus.i_start = 1'b0; bus.i_abort = 1'b0;
        checkOutput("abort+start ready", bus.o_ready, 1);
        checkOutput("abort+start sval", bus.o_sval, 0);
        tick();

        // Reset held two cycles in the middle of a frame.
        c = cyc;
        bus.i_start = 1'b1; bus.i_pattern = 8'hB5; bus.i_aux = 8'h4E; bus.i_len = 4'd8;
        for (int k = 1; k <= 3; k++) begin
            e.cyc = c + k; e.isDone = 1'b0; e.sd = bus.i_pattern[WIDTH-k]; e.sa = bus.i_aux[WIDTH-k];
            expQ.push_back(e);
        end
        tick(); bus.i_start = 1'b0;
        tick();
        tick(); reset = 1'b1;
        tick();
        tick(); reset = 1'b0;
        checkOutput("midframe reset ready", bus.o_ready, 1);
        checkOutput("midframe reset busy", bus.o_busy, 0);
        checkOutput("midframe reset sval", bus.o_sval, 0);
        checkOutput("midframe reset sdata", bus.o_sdata, 0);
        checkOutput("midframe reset done", bus.o_done, 0);
        tick();

        $display("[TB] randomized frames");
        for (int n = 0; n < 40; n++) begin
            int ln;
            ln = $urandom_range(0, 12);
            L = (ln == 0) ? 0 : ((ln > WIDTH) ? WIDTH : ln);
            ab = (L > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, L) : 0;
            pk = ($urandom_range(0, 1) == 1) && (L + GAP >= 4) && (ab == 0 || ab >= 4);
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), ln, ab, pk);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("[TB] zero-gap back-to-back frames");
        c = cyc;
        dones = 0;
        bus0.i_start = 1'b1; bus0.i_len = 4'd2; bus0.i_pattern = 8'b1000_0000; bus0.i_aux = 8'b0100_0000;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k == 9) bus0.i_start = 1'b0;
            case ((k - 1) % 3)
                0: begin
                    checkOutput("gap0 first bit sval", bus0.o_sval, 1);
                    checkOutput("gap0 first bit sdata", {bus0.o_sdata, bus0.o_saux}, 2'b10);
                    checkOutput("gap0 first bit ready", bus0.o_ready, 0);
                end
                1: begin
                    checkOutput("gap0 second bit sval", bus0.o_sval, 1);
                    checkOutput("gap0 second bit sdata", {bus0.o_sdata, bus0.o_saux}, 2'b01);
                    checkOutput("gap0 second bit ready", bus0.o_ready, 0);
                end
                default: begin
                    checkOutput("gap0 slot sval", bus0.o_sval, 0);
                    checkOutput("gap0 slot done", bus0.o_done, 1);
                    checkOutput("gap0 slot ready", bus0.o_ready, 1);
                end
            endcase
            if (bus0.o_done) dones++;
        end
        tick();
        checkOutput("gap0 stop ready", bus0.o_ready, 1);
        checkOutput("gap0 stop sval", bus0.o_sval, 0);
        checkOutput("gap0 done count", dones, 3);
        if (cyc != c + 10) checkOutput("gap0 cycle count", cyc, c + 10);

        repeat (4) tick();
        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
